// File: rtl/uart_echo_responder_pkg.sv
// Shared FSM state type, ASCII range constants and the letter case-swap helper
// for the UART echo responder.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } echo_state_t;

    localparam logic [7:0] ASCII_UPPER_A = 8'h41;
    localparam logic [7:0] ASCII_UPPER_Z = 8'h5A;
    localparam logic [7:0] ASCII_LOWER_A = 8'h61;
    localparam logic [7:0] ASCII_LOWER_Z = 8'h7A;
    localparam int         CASE_BIT      = 5;

    // Letters only; everything else, including the error substitute, passes through.
    function automatic logic [7:0] case_swap(input logic [7:0] b);
        logic [7:0] r;
        r = b;
        if ((b >= ASCII_UPPER_A && b <= ASCII_UPPER_Z) ||
            (b >= ASCII_LOWER_A && b <= ASCII_LOWER_Z))
            r[CASE_BIT] = ~b[CASE_BIT];
        return r;
    endfunction

endpackage

// File: rtl/uart_echo_responder_if.sv
// Signals between the echo responder, the rx/tx blocks and the display/debug logic.
// slave = responder side, master = surrounding environment.
interface uart_echo_responder_if #(
    parameter int LEVEL_W = 5
);
    logic [7:0]         rx_data;
    logic               rx_strobe;
    logic               rx_error;
    logic               tx_busy;
    logic [7:0]         tx_din;
    logic               tx_send;
    logic [LEVEL_W-1:0] fifo_level;
    logic [7:0]         err_count;
    logic [7:0]         ovf_count;
    logic [1:0]         state_dbg;

    modport slave (
        input  rx_data, rx_strobe, rx_error, tx_busy,
        output tx_din, tx_send, fifo_level, err_count, ovf_count, state_dbg
    );

    modport master (
        output rx_data, rx_strobe, rx_error, tx_busy,
        input  tx_din, tx_send, fifo_level, err_count, ovf_count, state_dbg
    );
endinterface

// File: rtl/uart_echo_responder_byte_fifo.sv
// Show-ahead byte FIFO with extra-MSB pointers; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic [7:0]             din,
    input  logic                   pop,
    output logic [7:0]             dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0] mem_q [DEPTH];
    logic [AW:0] wr_q;
    logic [AW:0] rd_q;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign level   = wr_q - rd_q;
    assign dout    = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    // Storage needs no reset: nothing is read until the pointers say it was written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din;
    end
endmodule

// File: rtl/uart_echo_responder.sv
// UART echo responder: queues bytes from rx and replays them through tx.
// Optional build macro UART_ECHO_CASE_SWAP_EN swaps letter case on the way out.
module uart_echo_responder
    import uart_pkg::*;
#(
    parameter int         DEPTH        = 16,
    parameter int         BUSY_TIMEOUT = 1023,
    parameter logic [7:0] ERR_SUB      = 8'h3F
) (
    input logic                  clk,
    input logic                  reset_n,
    uart_echo_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (BUSY_TIMEOUT > 0) ? $clog2(BUSY_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(BUSY_TIMEOUT);

    echo_state_t   state_q;
    logic [7:0]    tx_din_q;
    logic          tx_send_q;
    logic [CW-1:0] tmo_q;
    logic [7:0]    err_q;
    logic [7:0]    ovf_q;

    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic [7:0]    head;
    logic [7:0]    push_byte;
    logic [7:0]    launch_byte;
    logic [LW-1:0] level;

    assign pop       = (state_q == LAUNCH);
    assign push_byte = bus.rx_error ? ERR_SUB : bus.rx_data;

`ifdef UART_ECHO_CASE_SWAP_EN
    assign launch_byte = case_swap(head);
`else
    assign launch_byte = head;
`endif

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (bus.rx_strobe),
        .din     (push_byte),
        .pop     (pop),
        .dout    (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    // A full FIFO only drops the byte when no LAUNCH pop frees a slot this cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= '0;
            ovf_q <= '0;
        end else if (bus.rx_strobe) begin
            if (bus.rx_error && err_q != 8'hFF) err_q <= err_q + 8'd1;
            if (fifo_full && !pop && ovf_q != 8'hFF) ovf_q <= ovf_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            tx_din_q  <= '0;
            tx_send_q <= 1'b0;
            tmo_q     <= '0;
        end else begin
            tx_send_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!fifo_empty && !bus.tx_busy) state_q <= LAUNCH;
                end
                LAUNCH: begin
                    tx_din_q  <= launch_byte;
                    tx_send_q <= 1'b1;
                    tmo_q     <= '0;
                    state_q   <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // tx never acknowledged: the byte is abandoned, not retried.
                    if (bus.tx_busy)            state_q <= WAIT_DONE;
                    else if (tmo_q == TMO_LAST) state_q <= IDLE;
                    else                        tmo_q   <= tmo_q + 1'b1;
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.tx_din     = tx_din_q;
    assign bus.tx_send    = tx_send_q;
    assign bus.fifo_level = level;
    assign bus.err_count  = err_q;
    assign bus.ovf_count  = ovf_q;
    assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_uart_echo_responder.sv
// Directed bench for uart_echo_responder: expected echoes are queued at stimulus
// time and a negedge monitor compares every tx_send against the queue head.
`timescale 1ns/1ps
module tb_uart_echo_responder;
    localparam int DEPTH = 16;
    localparam int BT    = 1023;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    int errors        = 0;
    int checks        = 0;
    int cyc           = 0;
    int send_cnt      = 0;
    int last_send_cyc = 0;

    logic busy_force = 1'b0;
    logic model_busy = 1'b0;
    logic model_en   = 1'b1;
    int   busy_hold  = 100;

    logic [7:0] exp_q[$];

    uart_echo_responder_if #(.LEVEL_W(LW)) bus();

    uart_echo_responder #(
        .DEPTH        (DEPTH),
        .BUSY_TIMEOUT (BT),
        .ERR_SUB      (8'h3F)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign bus.tx_busy = busy_force | model_busy;

    function automatic logic [7:0] exp_byte(input logic [7:0] b);
`ifdef UART_ECHO_CASE_SWAP_EN
        if ((b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A))
            return b ^ 8'h20;
`endif
        return b;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [7:0] e;
        if (reset_n && bus.tx_send) begin
            send_cnt++;
            last_send_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_send: got tx_din=0x%02h expected no send", bus.tx_din);
            end else begin
                e = exp_q.pop_front();
                check("echo_byte", bus.tx_din, e);
            end
        end
    end

    // tx busy model: rises 2 cycles after a send, stays high busy_hold cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.tx_send && model_en) begin
                repeat (2) @(negedge clk);
                model_busy = 1'b1;
                repeat (busy_hold) @(negedge clk);
                model_busy = 1'b0;
            end
        end
    end

    initial begin
        #10ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic strobe(input logic [7:0] d, input logic err, output int t);
        @(negedge clk);
        t = cyc;
        bus.rx_data   = d;
        bus.rx_error  = err;
        bus.rx_strobe = 1'b1;
        @(negedge clk);
        bus.rx_strobe = 1'b0;
        bus.rx_error  = 1'b0;
    endtask

    task automatic wait_sends(input int target, input int budget, input string name);
        int n = 0;
        while (send_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, send_cnt, target);
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, input string name);
        int n = 0;
        while (bus.state_dbg != s && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, bus.state_dbg, s);
    endtask

    initial begin
        int t0, t1, n, base;
        bus.rx_data   = 8'h00;
        bus.rx_strobe = 1'b0;
        bus.rx_error  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_din", bus.tx_din, 0);
        check("rst_tx_send", bus.tx_send, 0);
        check("rst_level", bus.fifo_level, 0);
        check("rst_err", bus.err_count, 0);
        check("rst_ovf", bus.ovf_count, 0);
        check("rst_state", bus.state_dbg, 0);
        reset_n = 1'b1;

        // single byte, latency strobe -> tx_send = 3 cycles
        busy_hold = 100;
        exp_q.push_back(exp_byte(8'h41));
        strobe(8'h41, 1'b0, t0);
        wait_sends(1, 20, "t1_send");
        check("t1_latency", last_send_cyc - t0, 3);
        wait_state(2'd0, 300, "t1_idle");
        check("t1_level", bus.fifo_level, 0);
        check("t1_one_send", send_cnt, 1);

        // burst with overflow while tx is busy
        busy_hold  = 10;
        busy_force = 1'b1;
        for (int i = 0; i < DEPTH + 3; i++) begin
            if (i < DEPTH) exp_q.push_back(exp_byte(8'(i)));
            strobe(8'(i), 1'b0, t0);
        end
        check("t2_level_full", bus.fifo_level, DEPTH);
        check("t2_ovf", bus.ovf_count, 3);
        check("t2_held_idle", bus.state_dbg, 0);
        base = send_cnt;
        busy_force = 1'b0;
        wait_sends(base + DEPTH, 1000, "t2_drain_sends");
        wait_state(2'd0, 200, "t2_idle");
        check("t2_level_empty", bus.fifo_level, 0);
        check("t2_queue_empty", exp_q.size(), 0);

        // full FIFO, LAUNCH pop coincides with a strobe of 0xAA
        busy_force = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back(exp_byte(8'h80 + 8'(i)));
            strobe(8'h80 + 8'(i), 1'b0, t0);
        end
        check("t5_level_full", bus.fifo_level, DEPTH);
        base = send_cnt;
        @(negedge clk);
        busy_force = 1'b0;
        @(negedge clk);
        check("t5_in_launch", bus.state_dbg, 1);
        exp_q.push_back(exp_byte(8'hAA));
        bus.rx_data   = 8'hAA;
        bus.rx_strobe = 1'b1;
        @(negedge clk);
        bus.rx_strobe = 1'b0;
        check("t5_level_kept", bus.fifo_level, DEPTH);
        check("t5_no_ovf", bus.ovf_count, 3);
        wait_sends(base + DEPTH + 1, 1000, "t5_drain_sends");
        wait_state(2'd0, 200, "t5_idle");
        check("t5_level_empty", bus.fifo_level, 0);

        // timeout: busy never rises
        model_en = 1'b0;
        base = send_cnt;
        exp_q.push_back(exp_byte(8'h11));
        exp_q.push_back(exp_byte(8'h22));
        strobe(8'h11, 1'b0, t0);
        strobe(8'h22, 1'b0, t0);
        wait_state(2'd2, 20, "t4_wait_busy");
        t0 = cyc;
        n  = 0;
        while (bus.state_dbg == 2'd2 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        t1 = cyc;
        check("t4_timeout_cycles", t1 - t0, BT + 1);
        check("t4_back_idle", bus.state_dbg, 0);
        wait_sends(base + 2, 50, "t4_next_launched");
        wait_state(2'd2, 20, "t4_wait_busy2");
        wait_state(2'd0, 2000, "t4_idle2");
        model_en = 1'b1;

        // error substitution and saturation
        base = send_cnt;
        exp_q.push_back(exp_byte(8'h3F));
        strobe(8'h55, 1'b1, t0);
        check("t3_err_one", bus.err_count, 1);
        wait_sends(base + 1, 50, "t3_send");
        wait_state(2'd0, 200, "t3_idle");
        busy_force = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (i < DEPTH) exp_q.push_back(exp_byte(8'h3F));
            strobe(8'h55, 1'b1, t0);
        end
        check("t3_err_sat", bus.err_count, 255);
        check("t3_ovf_sat", bus.ovf_count, 255);
        check("t3_level_full", bus.fifo_level, DEPTH);
        base = send_cnt;
        busy_force = 1'b0;
        wait_sends(base + DEPTH, 1000, "t3_drain_sends");
        wait_state(2'd0, 200, "t3_idle2");

        // reset during WAIT_DONE with 5 bytes still queued
        busy_hold  = 100;
        busy_force = 1'b1;
        exp_q.push_back(exp_byte(8'h60));
        for (int i = 0; i < 6; i++) strobe(8'h60 + 8'(i), 1'b0, t0);
        busy_force = 1'b0;
        wait_state(2'd3, 50, "t6_wait_done");
        check("t6_level5", bus.fifo_level, 5);
        reset_n = 1'b0;
        #1;
        check("t6_rst_tx_din", bus.tx_din, 0);
        check("t6_rst_tx_send", bus.tx_send, 0);
        check("t6_rst_level", bus.fifo_level, 0);
        check("t6_rst_err", bus.err_count, 0);
        check("t6_rst_ovf", bus.ovf_count, 0);
        check("t6_rst_state", bus.state_dbg, 0);
        exp_q.delete();
        base = send_cnt;
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (200) @(negedge clk);
        check("t6_no_send", send_cnt, base);
        exp_q.push_back(exp_byte(8'h7E));
        strobe(8'h7E, 1'b0, t0);
        wait_sends(base + 1, 300, "t6_new_send");
        wait_state(2'd0, 300, "t6_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
